// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: double-dabble binary-to-BCD converter, one bit per clock,
// with start/done handshake, out-of-range detection and registered outputs.
module bin_to_bcd_seq #(
    parameter int BIN_WIDTH = 6,
    parameter int DIGITS    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [BIN_WIDTH-1:0]    shift_q, shift_d;
    logic [SW-1:0]           scratch_q, scratch_d, corr;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SW-1:0]           bcd_q, bcd_d;
    logic                    ovf_flag_q, ovf_flag_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    overflow_q, overflow_d;
    logic [SW+BIN_WIDTH-1:0] shifted;
    logic                    accept, in_shift, last;

    always_comb begin
        corr = scratch_q;
        for (int k = 0; k < DIGITS; k++)
            corr[4*k +: 4] = (scratch_q[4*k +: 4] >= 4'd5) ? scratch_q[4*k +: 4] + 4'd3
                                                            : scratch_q[4*k +: 4];
        shifted    = {corr, shift_q} << 1;
        in_shift   = state_q == SHIFT;
        accept     = start && !in_shift;
        last       = in_shift && (cnt_q == CW'(1));
        state_d    = accept ? SHIFT : last ? DONE : in_shift ? SHIFT : IDLE;
        shift_d    = accept ? bin : in_shift ? shifted[BIN_WIDTH-1:0] : shift_q;
        scratch_d  = accept ? '0 : in_shift ? shifted[SW+BIN_WIDTH-1:BIN_WIDTH] : scratch_q;
        cnt_d      = accept ? CW'(BIN_WIDTH) : in_shift ? cnt_q - CW'(1) : cnt_q;
        ovf_flag_d = accept ? ({{(64-BIN_WIDTH){1'b0}}, bin} >= LIMIT) : ovf_flag_q;
        busy_d     = state_d == SHIFT;
        done_d     = last;
        // out-of-range values show as all-ones digits so the display blanks them
        bcd_d      = last ? (ovf_flag_q ? '1 : shifted[SW+BIN_WIDTH-1:BIN_WIDTH]) : bcd_q;
        overflow_d = last ? ovf_flag_q : overflow_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            ovf_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            ovf_flag_q <= ovf_flag_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench over four configurations of the converter;
// stimulus pushes expected {overflow, bcd}, per-instance monitors pop on done.
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       s6 = 0, s7 = 0, s5 = 0, s10 = 0;
    logic [5:0] b6 = 0;
    logic [6:0] b7 = 0;
    logic [4:0] b5 = 0;
    logic [9:0] b10 = 0;
    logic       bz6, bz7, bz5, bz10, d6, d7, d5, d10, o6, o7, o5, o10;
    logic [7:0]  c6, c7, c5;
    logic [11:0] c10;

    bin_to_bcd_seq #(.BIN_WIDTH(6),  .DIGITS(2)) u6  (.clk(clk), .rst_n(rst_n), .start(s6),  .bin(b6),  .busy(bz6),  .done(d6),  .bcd(c6),  .overflow(o6));
    bin_to_bcd_seq #(.BIN_WIDTH(7),  .DIGITS(2)) u7  (.clk(clk), .rst_n(rst_n), .start(s7),  .bin(b7),  .busy(bz7),  .done(d7),  .bcd(c7),  .overflow(o7));
    bin_to_bcd_seq #(.BIN_WIDTH(5),  .DIGITS(2)) u5  (.clk(clk), .rst_n(rst_n), .start(s5),  .bin(b5),  .busy(bz5),  .done(d5),  .bcd(c5),  .overflow(o5));
    bin_to_bcd_seq #(.BIN_WIDTH(10), .DIGITS(3)) u10 (.clk(clk), .rst_n(rst_n), .start(s10), .bin(b10), .busy(bz10), .done(d10), .bcd(c10), .overflow(o10));

    typedef struct {int id; logic [12:0] v;} exp_t;
    exp_t sb[$];
    int errors = 0, checks = 0;
    int dc[4] = '{0, 0, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic ovf, input logic [11:0] bcd_exp);
        exp_t e;
        e.id = id;
        e.v  = {ovf, bcd_exp};
        sb.push_back(e);
    endtask

    // id: 0=W6D2, 1=W7D2, 2=W5D2, 3=W10D3
    task automatic mon(input int id, input logic [12:0] act, input logic bsy);
        exp_t e;
        dc[id]++;
        chk("busy_with_done", {31'd0, bsy}, 32'd0);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: inst %0d got %0h expected none", id, act);
        end else begin
            e = sb.pop_front();
            chk("done_inst", id, e.id);
            chk("result", {19'd0, act}, {19'd0, e.v});
        end
    endtask

    always @(negedge clk) if (rst_n && d6)  mon(0, {o6, 4'h0, c6}, bz6);
    always @(negedge clk) if (rst_n && d7)  mon(1, {o7, 4'h0, c7}, bz7);
    always @(negedge clk) if (rst_n && d5)  mon(2, {o5, 4'h0, c5}, bz5);
    always @(negedge clk) if (rst_n && d10) mon(3, {o10, c10}, bz10);

    task automatic drive(input int id, input logic s, input int v);
        case (id)
            0: begin s6 = s;  b6 = 6'(v);   end
            1: begin s7 = s;  b7 = 7'(v);   end
            2: begin s5 = s;  b5 = 5'(v);   end
            default: begin s10 = s; b10 = 10'(v); end
        endcase
    endtask

    task automatic go(input int id, input int v);
        @(posedge clk); #1;
        drive(id, 1'b1, v);
        @(posedge clk); #1;
        drive(id, 1'b0, v);
    endtask

    // n counts negedges after the accept edge up to and including the done cycle
    task automatic wait_done(input int id, output int n, output int b);
        logic dn, bz;
        n = 0;
        b = 0;
        dn = 0;
        while (!dn && n < 60) begin
            @(negedge clk);
            n++;
            dn = id == 0 ? d6 : id == 1 ? d7 : id == 2 ? d5 : d10;
            bz = id == 0 ? bz6 : id == 1 ? bz7 : id == 2 ? bz5 : bz10;
            if (bz) b++;
        end
        if (!dn) begin
            errors++;
            $display("FAIL timeout: inst %0d got no done expected done within 60 cycles", id);
        end
    endtask

    initial begin
        int n, b, d0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bz6}, 0);
        chk("rst_done", {31'd0, d6}, 0);
        chk("rst_bcd", {24'd0, c6}, 0);
        chk("rst_ovf", {31'd0, o6}, 0);
        chk("rst_bcd10", {20'd0, c10}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        push(0, 0, 12'h059);
        go(0, 59);
        wait_done(0, n, b);
        chk("lat_59", n, 7);
        chk("busy_cycles_59", b, 6);

        b6 = 0; s6 = 1; push(0, 0, 12'h000);
        for (int v = 1; v <= 64; v++) begin
            wait_done(0, n, b);
            if (v > 1) chk("b2b_gap", n, 7);
            if (v < 64) begin
                b6 = 6'(v);
                push(0, 0, {4'h0, 4'(v / 10), 4'(v % 10)});
            end else s6 = 0;
        end

        push(1, 1, 12'h0FF);
        go(1, 100);
        wait_done(1, n, b);
        push(1, 0, 12'h099);
        go(1, 99);
        wait_done(1, n, b);

        push(2, 0, 12'h023);
        go(2, 23);
        @(posedge clk); #1 drive(2, 1'b1, 7);
        @(posedge clk); #1 drive(2, 1'b0, 7);
        wait_done(2, n, b);
        repeat (10) @(posedge clk);
        chk("ignored_start_dones", dc[2], 1);

        push(3, 0, 12'h999);
        go(3, 999);
        wait_done(3, n, b);
        chk("lat_999", n, 11);
        push(3, 1, 12'hFFF);
        go(3, 1000);
        wait_done(3, n, b);

        d0 = dc[0];
        go(0, 45);
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, bz6}, 0);
        chk("abort_done", {31'd0, d6}, 0);
        chk("abort_bcd", {24'd0, c6}, 0);
        chk("abort_ovf", {31'd0, o6}, 0);
        repeat (10) @(posedge clk);
        chk("abort_no_done", dc[0], d0);
        push(0, 0, 12'h045);
        go(0, 45);
        wait_done(0, n, b);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
